// File: rtl/grid_display_if.sv
`default_nettype none
// ============================================================================
// Module      : grid_display_if
// Description : Grid-in / video-out bundle between game logic and raster scan.
// Revision    : 1.0 - initial release
// ============================================================================
interface grid_display_if;
    logic                  pix_en;
    logic [20:0][9:0][2:0] grid;
    logic                  hsync;
    logic                  vsync;
    logic                  de;
    logic [3:0]            red;
    logic [3:0]            green;
    logic [3:0]            blue;
    logic                  vblank_pulse;

    modport master (
        output pix_en, grid,
        input  hsync, vsync, de, red, green, blue, vblank_pulse
    );

    modport slave (
        input  pix_en, grid,
        output hsync, vsync, de, red, green, blue, vblank_pulse
    );
endinterface
`default_nettype wire

// File: rtl/grid_display.sv
`default_nettype none
// ============================================================================
// Module      : grid_display
// Description : VGA raster scan of a 21x10 playfield, snapshot once per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module grid_display #(
    parameter int CELL_SHIFT = 4,
    parameter int GRID_X0    = 240,
    parameter int GRID_Y0    = 72,
    parameter int BORDER_PX  = 2,
    parameter int H_VIS      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VIS      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  wire logic       clk,
    input  wire logic       rst,
    grid_display_if.slave   bus
);
    localparam logic [9:0]  c_H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  c_V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  c_H_VIS    = 10'(H_VIS);
    localparam logic [9:0]  c_V_VIS    = 10'(V_VIS);
    localparam logic [9:0]  c_HS_BEG   = 10'(H_VIS + H_FP);
    localparam logic [9:0]  c_HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  c_VS_BEG   = 10'(V_VIS + V_FP);
    localparam logic [9:0]  c_VS_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [10:0] c_GX0      = 11'(GRID_X0);
    localparam logic [10:0] c_GY0      = 11'(GRID_Y0);
    localparam logic [10:0] c_GW       = 11'(10 << CELL_SHIFT);
    localparam logic [10:0] c_GH       = 11'(21 << CELL_SHIFT);
    localparam logic [10:0] c_BX0      = 11'(GRID_X0 - BORDER_PX);
    localparam logic [10:0] c_BX1      = 11'(GRID_X0 + (10 << CELL_SHIFT) + BORDER_PX);
    localparam logic [10:0] c_BY0      = 11'(GRID_Y0 - BORDER_PX);
    localparam logic [10:0] c_BY1      = 11'(GRID_Y0 + (21 << CELL_SHIFT) + BORDER_PX);

    logic [9:0]            r_hcnt;
    logic [9:0]            r_vcnt;
    logic [20:0][9:0][2:0] r_grid_q;

    logic                  r_s1_vis;
    logic                  r_s1_in_grid;
    logic                  r_s1_in_border;
    logic                  r_s1_hs;
    logic                  r_s1_vs;
    logic [4:0]            r_s1_row;
    logic [3:0]            r_s1_col;

    logic                  r_hsync;
    logic                  r_vsync;
    logic                  r_de;
    logic [11:0]           r_rgb;
    logic                  r_vblank_pulse;

    logic [10:0]           w_hx;
    logic [10:0]           w_vy;
    logic [10:0]           w_dx;
    logic [10:0]           w_dy;
    logic                  w_in_grid;
    logic                  w_in_rect;
    logic                  w_vis;
    logic                  w_hs;
    logic                  w_vs;
    logic                  w_snap;
    logic [2:0]            w_cell;
    logic [11:0]           w_pal;

    assign w_hx      = {1'b0, r_hcnt};
    assign w_vy      = {1'b0, r_vcnt};
    assign w_dx      = w_hx - c_GX0;
    assign w_dy      = w_vy - c_GY0;
    assign w_in_grid = (w_hx >= c_GX0) && (w_dx < c_GW) && (w_vy >= c_GY0) && (w_dy < c_GH);
    assign w_in_rect = (w_hx >= c_BX0) && (w_hx < c_BX1) && (w_vy >= c_BY0) && (w_vy < c_BY1);
    assign w_vis     = (r_hcnt < c_H_VIS) && (r_vcnt < c_V_VIS);
    assign w_hs      = !((r_hcnt >= c_HS_BEG) && (r_hcnt < c_HS_END));
    assign w_vs      = !((r_vcnt >= c_VS_BEG) && (r_vcnt < c_VS_END));
    assign w_snap    = bus.pix_en && (r_hcnt == 10'd0) && (r_vcnt == c_V_VIS);

    // The snapshot is only indexed inside the playfield; outside it the cell reads as empty.
    always_comb begin
        w_cell = 3'd0;
        if (r_s1_in_grid) begin
            w_cell = r_grid_q[r_s1_row][r_s1_col];
        end
    end

    always_comb begin
        case (w_cell)
            3'd1:    w_pal = 12'h0FF;
            3'd2:    w_pal = 12'h00F;
            3'd3:    w_pal = 12'hF80;
            3'd4:    w_pal = 12'hFF0;
            3'd5:    w_pal = 12'h0F0;
            3'd6:    w_pal = 12'hF0F;
            3'd7:    w_pal = 12'hF00;
            default: w_pal = 12'h000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcnt         <= '0;
            r_vcnt         <= '0;
            r_grid_q       <= '0;
            r_s1_vis       <= 1'b0;
            r_s1_in_grid   <= 1'b0;
            r_s1_in_border <= 1'b0;
            r_s1_hs        <= 1'b1;
            r_s1_vs        <= 1'b1;
            r_s1_row       <= '0;
            r_s1_col       <= '0;
            r_hsync        <= 1'b1;
            r_vsync        <= 1'b1;
            r_de           <= 1'b0;
            r_rgb          <= '0;
            r_vblank_pulse <= 1'b0;
        end else begin
            r_vblank_pulse <= w_snap;
            if (w_snap) begin
                r_grid_q <= bus.grid;
            end
            if (bus.pix_en) begin
                if (r_hcnt == c_H_LAST) begin
                    r_hcnt <= '0;
                    r_vcnt <= (r_vcnt == c_V_LAST) ? 10'd0 : r_vcnt + 10'd1;
                end else begin
                    r_hcnt <= r_hcnt + 10'd1;
                end

                r_s1_vis       <= w_vis;
                r_s1_in_grid   <= w_in_grid;
                r_s1_in_border <= w_in_rect && !w_in_grid;
                r_s1_hs        <= w_hs;
                r_s1_vs        <= w_vs;
                r_s1_row       <= 5'(w_dy >> CELL_SHIFT);
                r_s1_col       <= 4'(w_dx >> CELL_SHIFT);

                r_hsync <= r_s1_hs;
                r_vsync <= r_s1_vs;
                r_de    <= r_s1_vis;
                if (!r_s1_vis) begin
                    r_rgb <= 12'h000;
                end else if (r_s1_in_grid) begin
                    r_rgb <= w_pal;
                end else if (r_s1_in_border) begin
                    r_rgb <= 12'h888;
                end else begin
                    r_rgb <= 12'h000;
                end
            end
        end
    end

    assign bus.hsync        = r_hsync;
    assign bus.vsync        = r_vsync;
    assign bus.de           = r_de;
    assign bus.red          = r_rgb[11:8];
    assign bus.green        = r_rgb[7:4];
    assign bus.blue         = r_rgb[3:0];
    assign bus.vblank_pulse = r_vblank_pulse;

endmodule
`default_nettype wire

// File: doc/grid_display.md
Name: grid_display

Overview:
- Read-side consumer of the playfield grid produced by the game FSM. Scans a 640x480@60 VGA raster.
- Takes a tear-free snapshot of the 21x10 color grid once per frame during vertical blanking.
- Maps each visible pixel to a playfield cell, border or background, and drives palette RGB and syncs to the video DAC/pins.

Parameters:
- CELL_SHIFT, 4: cell edge is 2^CELL_SHIFT pixels (16).
- GRID_X0, 240: x of the left edge of the playfield (column 0).
- GRID_Y0, 72: y of the top edge of the playfield (row 0).
- BORDER_PX, 2: width of the frame drawn around the playfield.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pix_en  in  1  pixel-clock enable. Counters and pipeline advance only when high.
- grid  in  21x10x3 ([20:0][9:0][2:0])  cell colors from the game FSM. 0 = empty; row 0 is the top.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- de  out  1  display enable, high on visible pixels.
- red  out  4  pixel red.
- green  out  4  pixel green.
- blue  out  4  pixel blue.
- vblank_pulse  out  1  one-clk pulse when the grid snapshot is taken.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - hcnt=0, vcnt=0.
  - snapshot grid_q=0.
  - All pipeline stages cleared.
  - hsync=1, vsync=1, de=0, red/green/blue=0, vblank_pulse=0.
- Counters (stage 0), updated only on pix_en:
  - hcnt runs 0..799 and wraps to 0.
  - vcnt increments when hcnt wraps; it runs 0..524 and wraps to 0.
- Horizontal timing: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
- Vertical timing: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
- Snapshot:
  - On the pix_en cycle where stage-0 (hcnt,vcnt)=(0,480), grid_q<=grid and vblank_pulse=1 for that clk only.
  - At all other times grid_q holds. grid changes outside that cycle are never visible mid-frame.
- Stage 1 (registered on pix_en), computed from stage-0 counters:
  - vis = hcnt<640 && vcnt<480.
  - Relative coordinates: dx=hcnt-GRID_X0 and dy=vcnt-GRID_Y0, computed at 11-bit unsigned width.
  - in_grid = hcnt>=GRID_X0 && dx<(10<<CELL_SHIFT) && vcnt>=GRID_Y0 && dy<(21<<CELL_SHIFT).
  - col = dx>>CELL_SHIFT and row = dy>>CELL_SHIFT. These are meaningful only when in_grid.
  - in_border: inside the rectangle enlarged by BORDER_PX on each side, and not in_grid.
  - Raw hsync/vsync levels are also registered in this stage.
- Stage 2 (registered on pix_en):
  - de = vis.
  - RGB is 0 when !vis. Otherwise priority is in_grid, then in_border, then background:
    - in_grid → palette(grid_q[row][col]).
    - in_border → 0x888.
    - else → 0x000.
  - hsync/vsync are the stage-1 copies, so syncs, de and RGB stay aligned.
- Latency: outputs reflect the counter position 2 pix_en ticks earlier.
- Palette (RGB 4:4:4):
  - 0 → 000
  - 1 → 0FF
  - 2 → 00F
  - 3 → F80
  - 4 → FF0
  - 5 → 0F0
  - 6 → F0F
  - 7 → F00
- pix_en low: all registers hold; outputs are static and vblank_pulse=0.
- Reset mid-frame: on the next clk the state equals the reset state, and scanning restarts at (0,0) with a black grid until the next snapshot.
- Index safety: row/col are never used when in_grid=0. Out-of-range indices (row>20, col>9) are impossible by construction and must not be decoded.

Test Plan:
- Reset, then pix_en=1 continuously → hsync first goes low 656+2 ticks after reset release and stays low 96 ticks. A full line is 800 ticks; vsync is low for exactly 1600 ticks (2 lines) starting at line 490; the frame is 420000 ticks.
- grid all 0 except grid[0][0]=1 and grid[20][9]=7, then run to the snapshot → in the next frame, pixel (240,72) = 0x0FF, pixel (399,407) = 0xF00, pixel (256,72) = 0x000, and pixel (238,72) = 0x888 (border).
- Change grid[5][3] from 0 to 4 while vcnt=200, then change it back before vcnt=480 → the current frame and the next both show 0x000 at pixel (288,152). vblank_pulse fires once per frame, at (0,480).
- Toggle pix_en 1-of-4 cycles → same pixel sequence as the continuous run, just stretched 4x. vblank_pulse is still one clk wide.
- Assert rst for 1 clk mid-frame at vcnt=300 → the next clk shows hsync=1, vsync=1, de=0, rgb=0. Counters restart and the grid renders black until the first snapshot.
- Check de against the counters over a frame → de is high for exactly 307200 pixels per frame and low on every blanking pixel, where rgb=0.
